// File: rtl/tcpc_reg_pkg.sv
// Shared types and constants for the TCPC register-interface masters.
package tcpc_reg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_e;

  localparam int unsigned MAX_BYTES_DEFAULT   = 4;
  localparam int unsigned TIMEOUT_CYC_DEFAULT = 16;

  localparam logic [7:0] REG_VENDOR_ID    = 8'h00;
  localparam logic [7:0] REG_DEVICE_ID    = 8'h04;
  localparam logic [7:0] REG_ALERT        = 8'h10;
  localparam logic [7:0] REG_COMMAND      = 8'h23;
  localparam logic [7:0] REG_TRANSMIT     = 8'h50;
  localparam logic [7:0] REG_VBUS_VOLTAGE = 8'h70;

  // Register address of byte idx of a multi-byte access; wraps at 8 bits.
  function automatic logic [7:0] reg_addr_at(input logic [7:0] base, input logic [7:0] idx);
    return base + idx;
  endfunction

endpackage

// File: rtl/tcpc_ack_timer.sv
// Loadable down-counter: expire is high for one cycle when a loaded count runs out.
module tcpc_ack_timer #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         clr,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         armed_q, armed_d;

  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    expire  = armed_q && (cnt_q == '0);
    if (clr) begin
      armed_d = 1'b0;
      cnt_d   = '0;
    end else if (load) begin
      armed_d = 1'b1;
      cnt_d   = load_val;
    end else if (expire) begin
      armed_d = 1'b0;
    end else if (armed_q) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/tcpc_reg_initiator.sv
// TCPC register-bus master: splits one host command into per-byte transfers with ACK timeout.
// Optional macro TCPC_REQ_RETRY_EN re-issues a timed-out byte once before failing.
module tcpc_reg_initiator
  import tcpc_reg_pkg::*;
#(
  parameter int unsigned MAX_BYTES   = MAX_BYTES_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic                           CLK,
  input  logic                           RESET_N,
  input  logic                           CMD_VALID,
  output logic                           CMD_READY,
  input  logic                           CMD_RNW,
  input  logic [7:0]                     CMD_ADDR,
  input  logic [$clog2(MAX_BYTES+1)-1:0] CMD_LEN,
  input  logic [8*MAX_BYTES-1:0]         CMD_WDATA,
  output logic                           RSP_VALID,
  output logic                           RSP_ERR,
  output logic [$clog2(MAX_BYTES+1)-1:0] RSP_COUNT,
  output logic [8*MAX_BYTES-1:0]         RSP_RDATA,
  output logic                           REQUEST,
  output logic                           RNW,
  output logic [7:0]                     ADDR,
  output logic [7:0]                     WR_DATA,
  input  logic [7:0]                     RD_DATA,
  input  logic                           ACK
);

  localparam int unsigned LW = $clog2(MAX_BYTES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  state_e                 state_q, state_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   cmd_rnw_q, cmd_rnw_d;
  logic [7:0]             cmd_addr_q, cmd_addr_d;
  logic [LW-1:0]          cmd_len_q, cmd_len_d;
  logic [8*MAX_BYTES-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [LW-1:0]          idx_q, idx_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [8*MAX_BYTES-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                   request_q, request_d;
  logic                   rnw_q, rnw_d;
  logic [7:0]             addr_q, addr_d;
  logic [7:0]             wr_data_q, wr_data_d;
`ifdef TCPC_REQ_RETRY_EN
  logic                   retry_q, retry_d;
`endif

  logic          do_issue;
  logic [LW-1:0] issue_idx;
  logic          tmr_load, tmr_clr, tmr_expire;

  tcpc_ack_timer #(.W(TW)) u_ack_timer (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .load     (tmr_load),
    .load_val (TW'(TIMEOUT_CYC - 1)),
    .clr      (tmr_clr),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    cmd_rnw_d   = cmd_rnw_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_len_d   = cmd_len_q;
    cmd_wdata_d = cmd_wdata_q;
    idx_d       = idx_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    request_d   = 1'b0;
    rnw_d       = rnw_q;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
`ifdef TCPC_REQ_RETRY_EN
    retry_d     = retry_q;
`endif
    do_issue    = 1'b0;
    issue_idx   = idx_q;
    tmr_load    = 1'b0;
    tmr_clr     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          cmd_ready_d = 1'b0;
          cmd_rnw_d   = CMD_RNW;
          cmd_addr_d  = CMD_ADDR;
          cmd_len_d   = CMD_LEN;
          cmd_wdata_d = CMD_WDATA;
          idx_d       = '0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
`ifdef TCPC_REQ_RETRY_EN
          retry_d     = 1'b0;
`endif
          state_d     = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (cmd_len_q == '0 || cmd_len_q > LW'(MAX_BYTES)) begin
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          do_issue = 1'b1;
        end
      end
      ST_ISSUE: begin
        tmr_load = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (ACK) begin
          tmr_clr = 1'b1;
          if (cmd_rnw_q) rsp_rdata_d[idx_q*8 +: 8] = RD_DATA;
          idx_d = idx_q + 1'b1;
`ifdef TCPC_REQ_RETRY_EN
          retry_d = 1'b0;
`endif
          if (idx_d == cmd_len_q) begin
            rsp_valid_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            do_issue  = 1'b1;
            issue_idx = idx_d;
          end
        end else if (tmr_expire) begin
`ifdef TCPC_REQ_RETRY_EN
          if (!retry_q) begin
            retry_d  = 1'b1;
            do_issue = 1'b1;
          end else begin
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = ST_DONE;
          end
`else
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = ST_DONE;
`endif
        end
      end
      ST_DONE: begin
        cmd_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        cmd_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase

    // Bus fields are loaded on entry to ISSUE so they are registered while REQUEST is high.
    if (do_issue) begin
      state_d   = ST_ISSUE;
      request_d = 1'b1;
      rnw_d     = cmd_rnw_q;
      addr_d    = reg_addr_at(cmd_addr_q, 8'(issue_idx));
      wr_data_d = cmd_wdata_q[issue_idx*8 +: 8];
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      cmd_rnw_q   <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
      cmd_wdata_q <= '0;
      idx_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      request_q   <= 1'b0;
      rnw_q       <= 1'b0;
      addr_q      <= '0;
      wr_data_q   <= '0;
`ifdef TCPC_REQ_RETRY_EN
      retry_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      cmd_rnw_q   <= cmd_rnw_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
      cmd_wdata_q <= cmd_wdata_d;
      idx_q       <= idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      request_q   <= request_d;
      rnw_q       <= rnw_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
`ifdef TCPC_REQ_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

  assign CMD_READY = cmd_ready_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_ERR   = rsp_err_q;
  assign RSP_COUNT = idx_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign REQUEST   = request_q;
  assign RNW       = rnw_q;
  assign ADDR      = addr_q;
  assign WR_DATA   = wr_data_q;

endmodule

// File: tb/tb_tcpc_reg_initiator.sv
// Directed bench for tcpc_reg_initiator with a behavioural register-file responder.
module tb_tcpc_reg_initiator;

`ifdef TCPC_REQ_RETRY_EN
  localparam int TO_EXTRA  = 17;
  localparam int RETRY_REQ = 1;
`else
  localparam int TO_EXTRA  = 0;
  localparam int RETRY_REQ = 0;
`endif

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b1;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic        CMD_RNW = 1'b0;
  logic [7:0]  CMD_ADDR = '0;
  logic [2:0]  CMD_LEN = '0;
  logic [31:0] CMD_WDATA = '0;
  logic        RSP_VALID;
  logic        RSP_ERR;
  logic [2:0]  RSP_COUNT;
  logic [31:0] RSP_RDATA;
  logic        REQUEST;
  logic        RNW;
  logic [7:0]  ADDR;
  logic [7:0]  WR_DATA;
  logic [7:0]  RD_DATA = '0;
  logic        ACK = 1'b0;

  always #5 CLK = ~CLK;

  tcpc_reg_initiator #(.MAX_BYTES(4), .TIMEOUT_CYC(16)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_RNW   (CMD_RNW),
    .CMD_ADDR  (CMD_ADDR),
    .CMD_LEN   (CMD_LEN),
    .CMD_WDATA (CMD_WDATA),
    .RSP_VALID (RSP_VALID),
    .RSP_ERR   (RSP_ERR),
    .RSP_COUNT (RSP_COUNT),
    .RSP_RDATA (RSP_RDATA),
    .REQUEST   (REQUEST),
    .RNW       (RNW),
    .ADDR      (ADDR),
    .WR_DATA   (WR_DATA),
    .RD_DATA   (RD_DATA),
    .ACK       (ACK)
  );

  // Responder: sees REQUEST in cycle k, answers with ACK during cycle k+1. 0x23 never ACKs.
  logic [7:0] regs [0:255];
  logic       ack_pend = 1'b0;
  logic [7:0] pend_rd = '0;
  logic       ack_force = 1'b0;
  logic [7:0] force_rd = '0;
  logic       prev_req = 1'b0;
  int         n_req = 0;
  int         req_double = 0;
  logic [7:0] addr_log [$];
  logic [7:0] wd_log [$];

  always @(negedge CLK) begin
    ACK     = ack_pend | ack_force;
    RD_DATA = ack_force ? force_rd : (ack_pend ? pend_rd : 8'h00);
    ack_pend = 1'b0;
    if (REQUEST) begin
      n_req++;
      addr_log.push_back(ADDR);
      wd_log.push_back(WR_DATA);
      if (prev_req) req_double++;
      if (ADDR != 8'h23) begin
        ack_pend = 1'b1;
        if (RNW) pend_rd = regs[ADDR];
        else     regs[ADDR] = WR_DATA;
      end
    end
    prev_req = REQUEST;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one command; returns the cycle (after the accept edge) in which RSP_VALID was seen, or -1.
  task automatic run_cmd(input logic rnw, input logic [7:0] addr, input logic [2:0] len,
                         input logic [31:0] wdata, output int rsp_cyc);
    @(negedge CLK);
    #2;
    CMD_VALID = 1'b1;
    CMD_RNW   = rnw;
    CMD_ADDR  = addr;
    CMD_LEN   = len;
    CMD_WDATA = wdata;
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b0;
    rsp_cyc = -1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge CLK);
      if (RSP_VALID) begin
        rsp_cyc = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic        rnw;
    logic [7:0]  addr;
    logic [2:0]  len;
    logic [31:0] wdata;
    logic        err;
    logic [2:0]  cnt;
    logic [31:0] rdata;
    int          cyc;
    int          nreq;
    logic [7:0]  a_first;
    logic [7:0]  a_last;
    logic [7:0]  wd_first;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   cyc;
    logic seen_rsp, seen_req;

    for (int a = 0; a < 256; a++) regs[a] = 8'h00;
    regs[8'h04] = 8'h34;
    regs[8'h05] = 8'h12;
    regs[8'h21] = 8'h01;
    regs[8'h22] = 8'h02;

    //          rnw   addr   len   wdata         err   cnt   rdata          cyc            nreq           first  last   wd0
    vecs[0]  = '{1'b0, 8'h10, 3'd2, 32'h0000A55A, 1'b0, 3'd2, 32'h00000000, 6,             2,             8'h10, 8'h11, 8'h5A};
    vecs[1]  = '{1'b1, 8'h10, 3'd2, 32'h00000000, 1'b0, 3'd2, 32'h0000A55A, 6,             2,             8'h10, 8'h11, 8'h00};
    vecs[2]  = '{1'b1, 8'h04, 3'd2, 32'h00000000, 1'b0, 3'd2, 32'h00001234, 6,             2,             8'h04, 8'h05, 8'h00};
    vecs[3]  = '{1'b1, 8'h23, 3'd1, 32'h00000000, 1'b1, 3'd0, 32'h00000000, 19 + TO_EXTRA, 1 + RETRY_REQ, 8'h23, 8'h23, 8'h00};
    vecs[4]  = '{1'b0, 8'hFF, 3'd2, 32'h0000BEEF, 1'b0, 3'd2, 32'h00000000, 6,             2,             8'hFF, 8'h00, 8'hEF};
    vecs[5]  = '{1'b1, 8'h00, 3'd0, 32'h00000000, 1'b1, 3'd0, 32'h00000000, 2,             0,             8'h00, 8'h00, 8'h00};
    vecs[6]  = '{1'b0, 8'h10, 3'd5, 32'hFFFFFFFF, 1'b1, 3'd0, 32'h00000000, 2,             0,             8'h00, 8'h00, 8'h00};
    vecs[7]  = '{1'b0, 8'h70, 3'd4, 32'h11223344, 1'b0, 3'd4, 32'h00000000, 10,            4,             8'h70, 8'h73, 8'h44};
    vecs[8]  = '{1'b1, 8'h70, 3'd4, 32'h00000000, 1'b0, 3'd4, 32'h11223344, 10,            4,             8'h70, 8'h73, 8'h00};
    vecs[9]  = '{1'b1, 8'h21, 3'd3, 32'h00000000, 1'b1, 3'd2, 32'h00000201, 23 + TO_EXTRA, 3 + RETRY_REQ, 8'h21, 8'h23, 8'h00};
    vecs[10] = '{1'b1, 8'hFF, 3'd2, 32'h00000000, 1'b0, 3'd2, 32'h0000BEEF, 6,             2,             8'hFF, 8'h00, 8'h00};

    // Reset state
    #1 RESET_N = 1'b0;
    #1;
    chk("reset CMD_READY", 64'(CMD_READY), 64'd1);
    chk("reset REQUEST",   64'(REQUEST),   64'd0);
    chk("reset RSP_VALID", 64'(RSP_VALID), 64'd0);
    chk("reset RSP_COUNT", 64'(RSP_COUNT), 64'd0);
    chk("reset RSP_RDATA", 64'(RSP_RDATA), 64'd0);
    chk("reset ADDR",      64'(ADDR),      64'd0);
    @(negedge CLK);
    #2 RESET_N = 1'b1;

    for (int i = 0; i < 11; i++) begin
      n_req = 0;
      addr_log.delete();
      wd_log.delete();
      chk($sformatf("v%0d ready", i), 64'(CMD_READY), 64'd1);
      run_cmd(vecs[i].rnw, vecs[i].addr, vecs[i].len, vecs[i].wdata, cyc);
      chk($sformatf("v%0d rsp_cycle", i), 64'(cyc), 64'(vecs[i].cyc));
      chk($sformatf("v%0d err", i),   64'(RSP_ERR),   64'(vecs[i].err));
      chk($sformatf("v%0d count", i), 64'(RSP_COUNT), 64'(vecs[i].cnt));
      chk($sformatf("v%0d rdata", i), 64'(RSP_RDATA), 64'(vecs[i].rdata));
      chk($sformatf("v%0d nreq", i),  64'(n_req),     64'(vecs[i].nreq));
      if (addr_log.size() > 0) begin
        chk($sformatf("v%0d addr_first", i), 64'(addr_log[0]), 64'(vecs[i].a_first));
        chk($sformatf("v%0d addr_last", i),  64'(addr_log[addr_log.size()-1]), 64'(vecs[i].a_last));
        chk($sformatf("v%0d wdata_first", i), 64'(wd_log[0]), 64'(vecs[i].wd_first));
      end
      @(negedge CLK);
      chk($sformatf("v%0d rsp_pulse_end", i), 64'(RSP_VALID), 64'd0);
      chk($sformatf("v%0d count_hold", i),    64'(RSP_COUNT), 64'(vecs[i].cnt));
      chk($sformatf("v%0d ready_after", i),   64'(CMD_READY), 64'd1);
    end

    // CMD_VALID held while busy must not start a second command
    n_req = 0;
    addr_log.delete();
    wd_log.delete();
    @(negedge CLK);
    #2;
    CMD_VALID = 1'b1; CMD_RNW = 1'b0; CMD_ADDR = 8'h50; CMD_LEN = 3'd1; CMD_WDATA = 32'h00000077;
    @(posedge CLK);
    #1;
    CMD_ADDR = 8'h60; CMD_WDATA = 32'h00000099;
    @(negedge CLK);
    chk("busy ready_low", 64'(CMD_READY), 64'd0);
    @(negedge CLK);
    @(negedge CLK);
    #2 CMD_VALID = 1'b0;
    cyc = -1;
    for (int k = 4; k <= 40; k++) begin
      @(negedge CLK);
      if (RSP_VALID) begin
        cyc = k;
        break;
      end
    end
    chk("busy rsp_cycle", 64'(cyc), 64'd4);
    repeat (10) @(negedge CLK);
    chk("busy nreq", 64'(n_req), 64'd1);
    chk("busy reg50", 64'(regs[8'h50]), 64'h77);
    chk("busy reg60", 64'(regs[8'h60]), 64'h00);

    // Spurious ACK in IDLE must leave the held response untouched
    @(negedge CLK);
    #2;
    force_rd = 8'hC3;
    ack_force = 1'b1;
    @(negedge CLK);
    #2 ack_force = 1'b0;
    seen_rsp = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      if (RSP_VALID) seen_rsp = 1'b1;
    end
    chk("spurious rsp_valid", 64'(seen_rsp),  64'd0);
    chk("spurious count",     64'(RSP_COUNT), 64'd1);
    chk("spurious rdata",     64'(RSP_RDATA), 64'd0);
    chk("spurious ready",     64'(CMD_READY), 64'd1);

    // Reset during the WAIT of byte 1 of a 4-byte write
    @(negedge CLK);
    #2;
    CMD_VALID = 1'b1; CMD_RNW = 1'b0; CMD_ADDR = 8'h70; CMD_LEN = 3'd4; CMD_WDATA = 32'hDEADBEEF;
    @(posedge CLK);
    #1 CMD_VALID = 1'b0;
    repeat (5) @(negedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    chk("rst REQUEST",   64'(REQUEST),   64'd0);
    chk("rst CMD_READY", 64'(CMD_READY), 64'd1);
    chk("rst RSP_COUNT", 64'(RSP_COUNT), 64'd0);
    chk("rst ADDR",      64'(ADDR),      64'd0);
    @(negedge CLK);
    #2 RESET_N = 1'b1;
    force_rd = 8'h5A;
    ack_force = 1'b1;
    @(negedge CLK);
    #2 ack_force = 1'b0;
    seen_rsp = 1'b0;
    seen_req = 1'b0;
    repeat (30) begin
      @(negedge CLK);
      if (RSP_VALID) seen_rsp = 1'b1;
      if (REQUEST)   seen_req = 1'b1;
    end
    chk("rst no_rsp",    64'(seen_rsp),  64'd0);
    chk("rst no_req",    64'(seen_req),  64'd0);
    chk("rst ready",     64'(CMD_READY), 64'd1);
    chk("rst rdata",     64'(RSP_RDATA), 64'd0);

    // Normal operation resumes after the reset
    run_cmd(1'b1, 8'h04, 3'd1, 32'h0, cyc);
    chk("post_rst cycle", 64'(cyc),       64'd4);
    chk("post_rst rdata", 64'(RSP_RDATA), 64'h34);
    chk("post_rst err",   64'(RSP_ERR),   64'd0);

    chk("request_never_held", 64'(req_double), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
